// File: rtl/lane_seg_top_mac_pipe.sv
// lane_seg_top_mac_pipe: pipelined signed MAC with grouped accumulation, round-half-up shift and saturation
// Ports: ap_clk/ap_rst_n clock and async active-low reset; in_valid/in_ready/din0/din1/first/last beat input;
// out_valid/out_ready/dout/sat_flag result output, one word per first..last group.
module lane_seg_top_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 13,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 12,
  parameter int NUM_STAGE  = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         sat_flag
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  // product stages S2..S(NUM_STAGE-1); the final stage reads the last entry
  localparam int D = NUM_STAGE - 2;
  localparam logic signed [ACC_WIDTH:0] RND = (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [ACC_WIDTH:0] MAXV = (ACC_WIDTH+1)'((64'sd1 <<< (DOUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] MINV = -MAXV - 1;
  logic                         en;
  logic signed [DIN0_WIDTH-1:0] a;
  logic signed [DIN1_WIDTH-1:0] b;
  logic                         v1, f1, l1;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  p [D];
  logic [D-1:0]                 v, f, l;
  logic signed [ACC_WIDTH-1:0]  acc, sum;
  logic signed [ACC_WIDTH:0]    ext, r;
  logic                         sat;
  logic signed [DOUT_WIDTH-1:0] dsat;
  // a single global enable freezes every stage while a result waits for the consumer
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  assign prod = a * b;
  assign sum = (f[D-1] ? '0 : acc) + p[D-1];
  assign ext = {sum[ACC_WIDTH-1], sum};
  assign r = (ext + RND) >>> SHIFT;
  assign sat = (r > MAXV) || (r < MINV);
  assign dsat = (r > MAXV) ? MAXV[DOUT_WIDTH-1:0] : (r < MINV) ? MINV[DOUT_WIDTH-1:0] : r[DOUT_WIDTH-1:0];
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a <= '0;
      b <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      for (int i = 0; i < D; i++) p[i] <= '0;
      v <= '0;
      f <= '0;
      l <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      dout <= '0;
      sat_flag <= 1'b0;
    end else if (en) begin
      a <= din0;
      b <= din1;
      v1 <= in_valid;
      f1 <= first;
      l1 <= last;
      p[0] <= ACC_WIDTH'(prod);
      v[0] <= v1;
      f[0] <= f1;
      l[0] <= l1;
      for (int i = 1; i < D; i++) begin
        p[i] <= p[i-1];
        v[i] <= v[i-1];
        f[i] <= f[i-1];
        l[i] <= l[i-1];
      end
      if (v[D-1]) acc <= l[D-1] ? '0 : sum;
      out_valid <= v[D-1] & l[D-1];
      if (v[D-1] & l[D-1]) begin
        dout <= dsat;
        sat_flag <= sat;
      end
    end
  end
endmodule

// File: tb/tb_lane_seg_top_mac_pipe.sv
// tb_lane_seg_top_mac_pipe: scoreboard bench for lane_seg_top_mac_pipe
module tb_lane_seg_top_mac_pipe;
  logic clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [15:0] din0 = '0;
  logic signed [12:0] din1 = '0;
  logic first = 1'b0;
  logic last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [15:0] dout;
  logic sat_flag;
  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  int cyc = 0;
  logic [16:0] q [$];
  logic stalled = 1'b0;
  logic [17:0] held = '0;

  lane_seg_top_mac_pipe dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .first(first), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] model(input longint s);
    logic signed [31:0] w;
    longint r;
    w = s[31:0];
    r = (longint'(w) + 2048) >>> 12;
    if (r > 32767) return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  always @(negedge clk) begin
    if (!ap_rst_n) stalled = 1'b0;
    else begin
      n_chk++;
      assert (in_ready === (!out_valid | out_ready)) else begin n_fail++; $error("FAIL in_ready got %b want %b", in_ready, !out_valid | out_ready); end
      if (stalled) begin
        n_chk++;
        assert ({out_valid, sat_flag, dout} === held[17:0]) else begin n_fail++; $error("FAIL hold got %h want %h", {out_valid, sat_flag, dout}, held); end
      end
      stalled = out_valid & !out_ready;
      held = {out_valid, sat_flag, dout};
      if (out_valid && out_ready) begin
        n_out++;
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $error("FAIL extra_output got dout=%0d want none", dout);
        end else begin
          logic [16:0] e;
          e = q.pop_front();
          assert ({sat_flag, dout} === e) else begin n_fail++; $error("FAIL result got sat=%b dout=%0d want sat=%b dout=%0d", sat_flag, dout, e[16], $signed(e[15:0])); end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d0, input int d1, input logic f, input logic l);
    logic ok;
    int n;
    din0 = d0[15:0];
    din1 = d1[12:0];
    first = f;
    last = l;
    in_valid = 1'b1;
    n = 0;
    do begin
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $error("FAIL send_timeout got no accept want accept within 50 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    n_chk++;
    assert (q.size() == 0) else begin n_fail++; $error("FAIL drain got %0d pending want 0", q.size()); end
  endtask

  initial begin
    int o;
    int t0;
    longint s;
    tick();
    n_chk++;
    assert ({out_valid, sat_flag, dout, in_ready} === {1'b0, 1'b0, 16'h0, 1'b1}) else begin n_fail++; $error("FAIL reset_state got %b%b %h %b want 00 0000 1", out_valid, sat_flag, dout, in_ready); end
    ap_rst_n = 1'b1;
    tick();
    // single product and latency
    q.push_back(17'd500);
    send(1000, 2048, 1, 1);
    n_chk++;
    assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL lat1 got %b want 0", out_valid); end
    tick();
    n_chk++;
    assert (out_valid === 1'b0) else begin n_fail++; $error("FAIL lat2 got %b want 0", out_valid); end
    tick();
    n_chk++;
    assert (out_valid === 1'b1) else begin n_fail++; $error("FAIL lat3 got %b want 1", out_valid); end
    drain();
    // rounding
    q.push_back(17'd2);
    send(3, 2048, 1, 1);
    q.push_back({1'b0, 16'hffff});
    send(-3, 2048, 1, 1);
    q.push_back(17'd0);
    send(1, 2047, 1, 1);
    drain();
    // saturation over 4-beat groups
    o = n_out;
    q.push_back({1'b1, 16'h7fff});
    for (int k = 0; k < 4; k++) send(32767, 4095, k == 0, k == 3);
    q.push_back({1'b1, 16'h8000});
    for (int k = 0; k < 4; k++) send(-32768, 4095, k == 0, k == 3);
    drain();
    n_chk++;
    assert (n_out - o == 2) else begin n_fail++; $error("FAIL sat_groups got %0d outputs want 2", n_out - o); end
    // backpressure
    o = n_out;
    fork
      for (int i = 0; i < 8; i++) begin
        q.push_back(model(longint'(1000 * (i + 1) - 3000) * 1234));
        send(1000 * (i + 1) - 3000, 1234, 1, 1);
      end
      for (int k = 0; k < 40; k++) begin
        out_ready = (k % 3 == 0);
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1'b1;
    drain();
    n_chk++;
    assert (n_out - o == 8) else begin n_fail++; $error("FAIL bp_count got %0d want 8", n_out - o); end
    // reset mid-group discards the partial sum
    send(400, 1024, 1, 0);
    repeat (4) tick();
    ap_rst_n = 1'b0;
    #1;
    n_chk++;
    assert ({out_valid, in_ready} === 2'b01) else begin n_fail++; $error("FAIL rst_mid got %b%b want 01", out_valid, in_ready); end
    tick();
    ap_rst_n = 1'b1;
    q.push_back(17'd5);
    send(20, 1024, 0, 1);
    q.push_back(17'd5);
    send(20, 1024, 1, 1);
    drain();
    // back-to-back groups of alternating length
    o = n_out;
    t0 = cyc;
    for (int g = 0; g < 10; g++) begin
      s = 0;
      for (int k = 0; k <= g % 2; k++) begin
        int a;
        int b;
        a = int'($urandom_range(65535)) - 32768;
        b = int'($urandom_range(8191)) - 4096;
        s += longint'(a) * b;
        if (k == g % 2) q.push_back(model(s));
        send(a, b, k == 0, k == g % 2);
      end
    end
    n_chk++;
    assert (cyc - t0 == 15) else begin n_fail++; $error("FAIL b2b_rate got %0d cycles want 15", cyc - t0); end
    drain();
    n_chk++;
    assert (n_out - o == 10) else begin n_fail++; $error("FAIL b2b_count got %0d want 10", n_out - o); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
